seq_multiplier: RTL

//  Iterative 32x32 RV32M multiplier (MUL/MULH/MULHSU/MULHU) for the core's execute stage.

---
 rtl/seq_multiplier_pkg.sv | 42 ++++
 rtl/seq_multiplier_adder.sv | 54 +++++
 rtl/seq_multiplier.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// seq_multiplier_pkg
// Shared definitions for the iterative RV32M multiplier: operation encodings,
// controller states, datapath sizing and small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package seq_multiplier_pkg;

    localparam int SEQMUL_XLEN  = 32;
    localparam int SEQMUL_NITER = 32;
    localparam int SEQMUL_CNTW  = 5;

    // RV32M multiply operations as encoded on op_i
    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_t;

    // Controller states, visited in this order for every operation
    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_NEG_LO,
        S_NEG_HI,
        S_DONE
    } state_t;

    // Multiplicand is treated as signed for MULH and MULHSU
    function automatic logic opSignedA(input op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    // Multiplier is treated as signed only for MULH
    function automatic logic opSignedB(input op_t op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/seq_multiplier_adder.sv
// -----------------------------------------------------------------------------
// Adder
// 32-bit carry-lookahead adder shared by every arithmetic step of the
// multiplier. Four-bit lookahead groups with group carries chained.
// With i_cin=1 it subtracts: o_sum = i_d1 + ~i_d2 + 1.
// Ports:
//   i_d1   in  32  first operand
//   i_d2   in  32  second operand (inverted internally when i_cin=1)
//   i_cin  in  1   carry in / subtract select
//   o_sum  out 32  sum
//   o_cout out 1   carry out of bit 31
// -----------------------------------------------------------------------------
module Adder (
    input  logic [31:0] i_d1,
    input  logic [31:0] i_d2,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    logic [31:0] w_b;
    logic [31:0] w_p;
    logic [31:0] w_g;
    logic [32:0] w_c;

    // Carries inside each 4-bit group are expanded from the group carry in,
    // so only the group carries ripple from one group to the next.
    always_comb begin
        w_b    = i_cin ? ~i_d2 : i_d2;
        w_p    = i_d1 ^ w_b;
        w_g    = i_d1 & w_b;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int k = 0; k < 8; k++) begin
            w_c[4*k+1] = w_g[4*k]
                       | (w_p[4*k] & w_c[4*k]);
            w_c[4*k+2] = w_g[4*k+1]
                       | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+3] = w_g[4*k+2]
                       | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+4] = w_g[4*k+3]
                       | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
        end
        o_sum  = w_p ^ w_c[31:0];
        o_cout = w_c[32];
    end

endmodule

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Iterative 32x32 RV32M multiplier (MUL/MULH/MULHSU/MULHU). Signed operands are
// converted to magnitudes, multiplied by 32 shift-add steps and the 64-bit
// product is negated back when the signs differ. All 32-bit arithmetic goes
// through one shared Adder instance whose inputs are selected by state.
// Fixed latency of 36 cycles from accept to valid_o.
// Optional build macro SEQMUL_ZERO_SKIP_EN: a zero operand skips straight from
// NEG_A to DONE with a zero result.
// Ports:
//   clk      in  1   clock, rising edge
//   rst_n    in  1   asynchronous active-low reset
//   start_i  in  1   request, accepted only when idle
//   op_i     in  2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1_i    in  32  multiplicand
//   rs2_i    in  32  multiplier
//   flush_i  in  1   synchronous abort, highest priority
//   busy_o   out 1   operation in flight
//   valid_o  out 1   result valid, held until ready_i
//   result_o out 32  MUL: product[31:0], MULH*: product[63:32]
//   ready_i  in  1   consumer accepts result
// -----------------------------------------------------------------------------
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int XLEN  = SEQMUL_XLEN,
    parameter int NITER = SEQMUL_NITER
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    input  logic            ready_i
);

    state_t                 r_state;
    state_t                 w_stateNext;
    op_t                    r_op;
    logic [XLEN-1:0]        r_a;
    logic [XLEN-1:0]        r_hi;
    logic [XLEN-1:0]        r_lo;
    logic [SEQMUL_CNTW-1:0] r_cnt;
    logic                   r_signA;
    logic                   r_signB;
    logic                   r_carry;

    logic [XLEN-1:0]        w_d1;
    logic [XLEN-1:0]        w_d2;
    logic                   w_cin;
    logic [XLEN-1:0]        w_sum;
    logic                   w_cout;
    logic                   w_negA;
    logic                   w_negB;
    logic                   w_negP;

    Adder u_adder (
        .i_d1   (w_d1),
        .i_d2   (w_d2),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_negA = opSignedA(r_op) && r_a[XLEN-1];
    assign w_negB = opSignedB(r_op) && r_lo[XLEN-1];
    assign w_negP = r_signA ^ r_signB;

    // Next-state logic and the adder input mux. Negation steps always use
    // d1=0/cin=1 so the adder yields 0-x; NEG_HI finishes the 64-bit negate
    // by adding the low-half carry to the inverted high half.
    always_comb begin
        w_stateNext = r_state;
        w_d1        = '0;
        w_d2        = '0;
        w_cin       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) w_stateNext = S_NEG_A;
            end
            S_NEG_A: begin
                w_d2        = r_a;
                w_cin       = 1'b1;
                w_stateNext = S_NEG_B;
`ifdef SEQMUL_ZERO_SKIP_EN
                if ((r_a == '0) || (r_lo == '0)) w_stateNext = S_DONE;
`endif
            end
            S_NEG_B: begin
                w_d2        = r_lo;
                w_cin       = 1'b1;
                w_stateNext = S_ITER;
            end
            S_ITER: begin
                w_d1 = r_hi;
                w_d2 = r_lo[0] ? r_a : '0;
                if (r_cnt == SEQMUL_CNTW'(NITER - 1)) w_stateNext = S_NEG_LO;
            end
            S_NEG_LO: begin
                w_d2        = r_lo;
                w_cin       = 1'b1;
                w_stateNext = S_NEG_HI;
            end
            S_NEG_HI: begin
                w_d1        = ~r_hi;
                w_d2        = {{(XLEN-1){1'b0}}, r_carry};
                w_stateNext = S_DONE;
            end
            S_DONE: begin
                if (ready_i) w_stateNext = S_IDLE;
            end
            default: w_stateNext = S_IDLE;
        endcase
        if (flush_i) w_stateNext = S_IDLE;
    end

    // State register plus datapath updates. Each ITER step shifts the 65-bit
    // {carry, sum, lo} right by one, so the adder carry lands in hi[31].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_MUL;
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_signA <= 1'b0;
            r_signB <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        r_op    <= op_t'(op_i);
                        r_a     <= rs1_i;
                        r_lo    <= rs2_i;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        r_signA <= 1'b0;
                        r_signB <= 1'b0;
                        r_carry <= 1'b0;
                    end
                end
                S_NEG_A: begin
                    r_signA <= w_negA;
                    if (w_negA) r_a <= w_sum;
`ifdef SEQMUL_ZERO_SKIP_EN
                    if ((r_a == '0) || (r_lo == '0)) begin
                        r_lo    <= '0;
                        r_signA <= 1'b0;
                    end
`endif
                end
                S_NEG_B: begin
                    r_signB <= w_negB;
                    if (w_negB) r_lo <= w_sum;
                end
                S_ITER: begin
                    r_hi  <= {w_cout, w_sum[XLEN-1:1]};
                    r_lo  <= {w_sum[0], r_lo[XLEN-1:1]};
                    r_cnt <= r_cnt + SEQMUL_CNTW'(1);
                end
                S_NEG_LO: begin
                    r_carry <= w_cout;
                    if (w_negP) r_lo <= w_sum;
                end
                S_NEG_HI: begin
                    if (w_negP) r_hi <= w_sum;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (r_state != S_IDLE);
    assign valid_o  = (r_state == S_DONE);
    assign result_o = valid_o ? ((r_op == OP_MUL) ? r_lo : r_hi) : '0;

endmodule
